crc16_frame_calc: RTL and testbench

Byte-stream CRC-16 engine feeding the CRC compare stage. It accepts a frame of `frame_len` payload bytes followed by a 2-byte transmitted hash. It computes CRC-16/CCITT-FALSE over the payload and captures the hash. It then presents `crc_calc`/`crc_hash` with `crc_start`/`crc_rdy` strobes, directly compatible with the downstream comparator's inputs.

---
 rtl/crc_pkg.sv | 38 +++
 rtl/crc16_lfsr.sv | 33 +++
 rtl/crc16_frame_calc.sv | 133 +++++++++++++
 tb/tb_crc16_frame_calc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC-16/CCITT-FALSE constants, FSM states and update helpers.
// Parallel byte folding is selected with the CRC_PARALLEL_EN macro.
package crc_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DATA    = 3'd1,
    S_SHIFT   = 3'd2,
    S_HASH_HI = 3'd3,
    S_HASH_LO = 3'd4,
    S_DONE    = 3'd5
  } crc_state_t;

  function automatic logic [15:0] crc16_bit(
    input logic [15:0] crc,
    input logic        b
  );
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  d
  );
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = crc16_bit(c, d[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_lfsr.sv
// 16-bit CRC register: bit-serial step, or whole-byte step when
// CRC_PARALLEL_EN is defined.
module crc16_lfsr
  import crc_pkg::*;
(
  input  logic        clk50m,
  input  logic        rst,
  input  logic        init,
  input  logic        shift_bit,
  input  logic        bit_in,
`ifdef CRC_PARALLEL_EN
  input  logic        load_byte,
  input  logic [7:0]  byte_in,
`endif
  output logic [15:0] crc
);

  // CRC register; init wins over any update in the same cycle
  always_ff @(posedge clk50m) begin
    if (rst) begin
      crc <= '0;
    end else if (init) begin
      crc <= CRC_INIT;
`ifdef CRC_PARALLEL_EN
    end else if (load_byte) begin
      crc <= crc16_byte(crc, byte_in);
`endif
    end else if (shift_bit) begin
      crc <= crc16_bit(crc, bit_in);
    end
  end

endmodule

// File: rtl/crc16_frame_calc.sv
// Frame CRC-16 engine: payload CRC plus captured 2-byte hash.
// Define CRC_PARALLEL_EN for 1 byte/cycle; default is bit-serial.
module crc16_frame_calc
  import crc_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk50m,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             busy,
  output logic             crc_start,
  output logic             crc_rdy,
  output logic [15:0]      crc_calc,
  output logic [15:0]      crc_hash
);

  crc_state_t       state;
  logic [LEN_W-1:0] remaining;
  logic             xfer;
  logic             lfsr_shift;
  logic             lfsr_bit;

`ifndef CRC_PARALLEL_EN
  logic [7:0]       sh_byte;
  logic [2:0]       bit_cnt;
`else
  logic             lfsr_load;
`endif

  assign byte_ready = (state == S_DATA)
                   || (state == S_HASH_HI)
                   || (state == S_HASH_LO);
  assign busy       = (state != S_IDLE);
  assign crc_rdy    = (state == S_DONE);
  assign xfer       = byte_valid && byte_ready;

`ifndef CRC_PARALLEL_EN
  assign lfsr_shift = (state == S_SHIFT) && !frame_start;
  assign lfsr_bit   = sh_byte[7];
`else
  assign lfsr_shift = 1'b0;
  assign lfsr_bit   = 1'b0;
  assign lfsr_load  = (state == S_DATA) && xfer && !frame_start;
`endif

  crc16_lfsr u_lfsr (
    .clk50m    (clk50m),
    .rst       (rst),
    .init      (frame_start),
    .shift_bit (lfsr_shift),
    .bit_in    (lfsr_bit),
`ifdef CRC_PARALLEL_EN
    .load_byte (lfsr_load),
    .byte_in   (byte_data),
`endif
    .crc       (crc_calc)
  );

  // Frame sequencing; frame_start restarts from any state
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      crc_start <= 1'b0;
      crc_hash  <= '0;
`ifndef CRC_PARALLEL_EN
      sh_byte   <= '0;
      bit_cnt   <= '0;
`endif
    end else begin
      crc_start <= 1'b0;
      if (frame_start) begin
        crc_start <= 1'b1;
        remaining <= frame_len;
        state     <= (frame_len != '0) ? S_DATA : S_HASH_HI;
      end else begin
        unique case (state)
          S_IDLE: begin
          end
          S_DATA: begin
            if (xfer) begin
              remaining <= remaining - LEN_W'(1);
`ifndef CRC_PARALLEL_EN
              sh_byte   <= byte_data;
              bit_cnt   <= '0;
              state     <= S_SHIFT;
`else
              if (remaining == LEN_W'(1)) begin
                state <= S_HASH_HI;
              end
`endif
            end
          end
          S_SHIFT: begin
`ifndef CRC_PARALLEL_EN
            sh_byte <= {sh_byte[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= (remaining != '0) ? S_DATA : S_HASH_HI;
            end
`else
            state <= S_IDLE;
`endif
          end
          S_HASH_HI: begin
            if (xfer) begin
              crc_hash[15:8] <= byte_data;
              state          <= S_HASH_LO;
            end
          end
          S_HASH_LO: begin
            if (xfer) begin
              crc_hash[7:0] <= byte_data;
              state         <= S_DONE;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc16_frame_calc.sv
// Randomised frame bench for crc16_frame_calc.
// Checks against a byte-wise CRC-16/CCITT-FALSE reference model.
module tb_crc16_frame_calc;

  logic        clk50m = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [15:0] frame_len = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        busy;
  logic        crc_start;
  logic        crc_rdy;
  logic [15:0] crc_calc;
  logic [15:0] crc_hash;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_start = 0;
  int n_rdy = 0;
  int n_both = 0;

`ifdef CRC_PARALLEL_EN
  localparam int BYTE_CYC = 1;
`else
  localparam int BYTE_CYC = 9;
`endif

  crc16_frame_calc dut (
    .clk50m      (clk50m),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_len   (frame_len),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .busy        (busy),
    .crc_start   (crc_start),
    .crc_rdy     (crc_rdy),
    .crc_calc    (crc_calc),
    .crc_hash    (crc_hash)
  );

  always #10 clk50m = ~clk50m;

  always @(posedge clk50m) begin
    cyc++;
    #1;
    if (crc_start) n_start++;
    if (crc_rdy) n_rdy++;
    if (crc_start && crc_rdy) n_both++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [7:0] q[$]);
    int c;
    c = 'hFFFF;
    foreach (q[i]) begin
      c = c ^ (int'(q[i]) << 8);
      for (int k = 0; k < 8; k++) begin
        if ((c & 'h8000) != 0) c = ((c << 1) ^ 'h1021) & 'hFFFF;
        else c = (c << 1) & 'hFFFF;
      end
    end
    return c[15:0];
  endfunction

  task automatic start_frame(input int len);
    frame_start = 1'b1;
    frame_len = len[15:0];
    @(negedge clk50m);
    frame_start = 1'b0;
    byte_valid = 1'b0;
    chk("start_pulse", {31'd0, crc_start}, 32'd1);
    chk("busy_start", {31'd0, busy}, 32'd1);
  endtask

  // Offers q[0..cnt-1]; records acceptance cycles of payload bytes
  task automatic feed(input logic [7:0] q[$], input int cnt,
                      input int npay, input int gap);
    int idx, spins, last;
    logic v, x;
    idx = 0;
    spins = 0;
    last = -1;
    while (idx < cnt && spins < 3000) begin
      v = ($urandom_range(99) >= gap);
      byte_valid = v;
      byte_data = q[idx];
      x = v && byte_ready;
      @(negedge clk50m);
      spins++;
      if (x) begin
        if (gap == 0 && idx < npay && last >= 0)
          chk("byte_spacing", cyc - last, BYTE_CYC);
        if (idx < npay) last = cyc;
        idx++;
      end
    end
    byte_valid = 1'b0;
    if (idx < cnt) chk("feed_timeout", idx, cnt);
  endtask

  task automatic run_frame(input logic [7:0] pay[$],
                           input logic [15:0] hash, input int gap);
    logic [7:0] q[$];
    int r0;
    q = pay;
    q.push_back(hash[15:8]);
    q.push_back(hash[7:0]);
    r0 = n_rdy;
    start_frame(pay.size());
    feed(q, q.size(), pay.size(), gap);
    chk("rdy_latency", {31'd0, crc_rdy}, 32'd1);
    chk("crc_calc", crc_calc, ref_crc(pay));
    chk("crc_hash", crc_hash, hash);
    @(negedge clk50m);
    chk("busy_drop", {31'd0, busy}, 32'd0);
    chk("hold_calc", crc_calc, ref_crc(pay));
    chk("rdy_count", n_rdy - r0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_start"}, {31'd0, crc_start}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, crc_rdy}, 32'd0);
    chk({tag, "_calc"}, crc_calc, 32'd0);
    chk({tag, "_hash"}, crc_hash, 32'd0);
  endtask

  initial begin
    logic [7:0] s9[$];
    logic [7:0] p[$];
    logic [7:0] q[$];
    int s0, r0, w, len;

    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
           8'h36, 8'h37, 8'h38, 8'h39};

    repeat (3) @(negedge clk50m);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk50m);

    run_frame(s9, 16'h29B1, 0);
    chk("model_check", ref_crc(s9), 32'h29B1);

    p = '{8'h00};
    run_frame(p, 16'h1234, 0);

    p = {};
    run_frame(p, 16'hFFFF, 0);

    // Abort after 4 bytes, with a byte offered in the abort cycle
    s0 = n_start;
    r0 = n_rdy;
    start_frame(9);
    feed(s9, 4, 9, 0);
    w = 0;
    while (!byte_ready && w < 20) begin
      @(negedge clk50m);
      w++;
    end
    chk("abort_ready", {31'd0, byte_ready}, 32'd1);
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    q = s9;
    q.push_back(8'h29);
    q.push_back(8'hB1);
    start_frame(9);
    feed(q, q.size(), 9, 0);
    chk("abort_calc", crc_calc, 32'h29B1);
    repeat (2) @(negedge clk50m);
    chk("abort_starts", n_start - s0, 2);
    chk("abort_rdys", n_rdy - r0, 1);

    // Reset while the serial engine is shifting
    r0 = n_rdy;
    start_frame(9);
    feed(s9, 1, 9, 0);
    @(negedge clk50m);
    rst = 1'b1;
    @(negedge clk50m);
    chk_zero("midrst");
    rst = 1'b0;
    @(negedge clk50m);
    chk("midrst_rdys", n_rdy - r0, 0);
    run_frame(s9, 16'h29B1, 0);

    run_frame(s9, 16'h29B1, 40);

    for (int f = 0; f < 6; f++) begin
      p = {};
      len = $urandom_range(20);
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      run_frame(p, 16'($urandom), 30);
    end

    chk("start_rdy_overlap", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
